// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path.
package uart_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEPTH_DEFAULT = 16;

  // One buffered byte plus its frame-error tag.
  typedef struct packed {
    logic              err;
    logic [BYTE_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - show-ahead read port of the receive FIFO.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] m_data;
  logic              m_err;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_err,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_err,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x entry register array, sync write, async read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with error tagging and sticky overflow.
// Optional statistics counters enabled by UART_RX_FIFO_STATS_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = DEPTH_DEFAULT,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_busy,
  input  logic              rx_error,
  uart_rx_fifo_if.master    rd,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]       byte_cnt,
  output logic [15:0]       err_cnt,
  input  logic              stats_clr
`endif
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              rx_done_q, rx_done_d;
  logic              rx_busy_q, rx_busy_d;
  logic              err_pend_q, err_pend_d;

  logic   done_rise;
  logic   rd_fire;
  logic   wr_fire;
  logic   ovf_set;
  entry_t wr_entry;
  entry_t rd_entry;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign done_rise = rx_done & ~rx_done_q;
  assign rd_fire   = ~empty & rd.m_ready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_fire   = done_rise & (~full | rd_fire);
  assign ovf_set   = done_rise & full & ~rd_fire;

  assign wr_entry.err  = err_pend_q | rx_error;
  assign wr_entry.data = rx_data;

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign rd.m_valid = ~empty;
  assign rd.m_data  = empty ? '0   : rd_entry.data;
  assign rd.m_err   = empty ? 1'b0 : rd_entry.err;
  assign count      = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rx_done_d  = rx_done;
    rx_busy_d  = rx_busy;
    err_pend_d = err_pend_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    if (wr_fire && !rd_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (rd_fire && !wr_fire) begin
      count_d = count_q - CNT_W'(1);
    end

    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    // Error seen mid-frame sticks until the frame ends either way.
    if (done_rise) begin
      err_pend_d = 1'b0;
    end else if (rx_error && rx_busy) begin
      err_pend_d = 1'b1;
    end else if (rx_busy_q && !rx_busy) begin
      err_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rx_done_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rx_done_q  <= rx_done_d;
      rx_busy_q  <= rx_busy_d;
      err_pend_q <= err_pend_d;
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (stats_clr) begin
      byte_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (wr_fire) begin
      byte_cnt_d = byte_cnt_q + 16'd1;
      if (wr_entry.err) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign byte_cnt = byte_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed vector bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_error;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] byte_cnt;
  logic [15:0] err_cnt;
  logic        stats_clr;
`endif

  uart_rx_fifo_if rd_if ();

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .rx_error (rx_error),
    .rd       (rd_if),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .byte_cnt  (byte_cnt),
    .err_cnt   (err_cnt),
    .stats_clr (stats_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         done;
    bit         busy;
    bit         err;
    bit         rdy;
    int         e_cnt;
    bit         e_val;
    logic [7:0] e_data;
    bit         e_err;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic addv(input logic [7:0] d, input bit done, input bit busy, input bit err,
                      input bit rdy, input int e_cnt, input bit e_val,
                      input logic [7:0] e_data, input bit e_err);
    vec_t v;
    v.d = d; v.done = done; v.busy = busy; v.err = err; v.rdy = rdy;
    v.e_cnt = e_cnt; v.e_val = e_val; v.e_data = e_data; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_done = 0; rx_busy = 0; rx_error = 0;
    ovf_clr = 0; rd_if.m_ready = 0;
`ifdef UART_RX_FIFO_STATS_EN
    stats_clr = 0;
`endif
    tick(); tick();
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_valid", int'(rd_if.m_valid), 0);
    chk("reset_data", int'(rd_if.m_data), 0);
    chk("reset_err", int'(rd_if.m_err), 0);
    chk("reset_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    tick();

    //    data  dn bz er rd  cnt val data  err
    addv(8'h55, 1, 0, 0, 0,  1, 1, 8'h55, 0);
    addv(8'h00, 0, 0, 0, 0,  1, 1, 8'h55, 0);
    addv(8'hA3, 1, 0, 0, 0,  2, 1, 8'h55, 0);
    addv(8'h00, 0, 0, 0, 0,  2, 1, 8'h55, 0);
    addv(8'h0F, 1, 0, 0, 0,  3, 1, 8'h55, 0);
    addv(8'h00, 0, 0, 0, 0,  3, 1, 8'h55, 0);
    addv(8'h00, 0, 0, 0, 1,  2, 1, 8'hA3, 0);
    addv(8'h00, 0, 0, 0, 1,  1, 1, 8'h0F, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h00, 0, 1, 1, 0,  0, 0, 8'h00, 0);
    addv(8'h00, 0, 1, 0, 0,  0, 0, 8'h00, 0);
    addv(8'h7E, 1, 1, 0, 0,  1, 1, 8'h7E, 1);
    addv(8'h00, 0, 0, 0, 0,  1, 1, 8'h7E, 1);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h11, 1, 1, 0, 0,  1, 1, 8'h11, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h00, 0, 0, 1, 0,  0, 0, 8'h00, 0);
    addv(8'h00, 0, 1, 0, 0,  0, 0, 8'h00, 0);
    addv(8'h22, 1, 1, 0, 0,  1, 1, 8'h22, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h33, 1, 0, 0, 0,  1, 1, 8'h33, 0);
    addv(8'h44, 1, 0, 0, 0,  1, 1, 8'h33, 0);
    addv(8'h44, 1, 0, 0, 0,  1, 1, 8'h33, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);
    addv(8'h55, 1, 0, 0, 1,  1, 1, 8'h55, 0);
    addv(8'h00, 0, 0, 0, 1,  0, 0, 8'h00, 0);

    foreach (vq[i]) begin
      rx_data = vq[i].d; rx_done = vq[i].done; rx_busy = vq[i].busy;
      rx_error = vq[i].err; rd_if.m_ready = vq[i].rdy;
      tick();
      n_chk++;
      if (int'(count) != vq[i].e_cnt || rd_if.m_valid !== vq[i].e_val ||
          rd_if.m_data !== vq[i].e_data || rd_if.m_err !== vq[i].e_err || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d: actual cnt=%0d val=%0b data=%02h err=%0b ovf=%0b required cnt=%0d val=%0b data=%02h err=%0b ovf=0",
                 i, count, rd_if.m_valid, rd_if.m_data, rd_if.m_err, overflow,
                 vq[i].e_cnt, vq[i].e_val, vq[i].e_data, vq[i].e_err);
      end
    end
    rx_busy = 0; rx_error = 0; rd_if.m_ready = 0;

    for (int i = 0; i < 17; i++) pulse(8'(i));
    chk("ovf_count", int'(count), 16);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    chk("ovf_clr", int'(overflow), 0);
    rd_if.m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_rd%0d", i), int'(rd_if.m_data), i);
      tick();
    end
    rd_if.m_ready = 0;
    chk("ovf_drained", int'(empty), 1);

    for (int i = 0; i < 16; i++) pulse(8'(8'h80 + i));
    rx_data = 8'hAA; rx_done = 1; rd_if.m_ready = 1; tick();
    rx_done = 0; rd_if.m_ready = 0;
    chk("simul_count", int'(count), 16);
    chk("simul_ovf", int'(overflow), 0);
    chk("simul_head", int'(rd_if.m_data), 8'h81);
    tick();
    rx_data = 8'hBB; rx_done = 1; ovf_clr = 1; tick();
    rx_done = 0; ovf_clr = 0;
    chk("setwins_ovf", int'(overflow), 1);
    chk("setwins_count", int'(count), 16);
    tick();
    rd_if.m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("simul_rd%0d", i), int'(rd_if.m_data), (i < 15) ? 8'h81 + i : 8'hAA);
      tick();
    end
    rd_if.m_ready = 0;
    chk("simul_drained", int'(empty), 1);

    for (int i = 0; i < 5; i++) pulse(8'(8'h60 + i));
    chk("pre_rst_count", int'(count), 5);
`ifdef UART_RX_FIFO_STATS_EN
    chk("stats_bytes", int'(byte_cnt), 46);
    chk("stats_errs", int'(err_cnt), 1);
    stats_clr = 1; tick(); stats_clr = 0;
    chk("stats_clr_bytes", int'(byte_cnt), 0);
    chk("stats_clr_errs", int'(err_cnt), 0);
`endif
    #2; rst_n = 0; #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(rd_if.m_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_empty", int'(empty), 1);
    tick(); rst_n = 1; tick();
    pulse(8'h5A);
    chk("post_rst_head", int'(rd_if.m_data), 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
